gcd_spi_ctrl: RTL

Sequencing controller between an operand source and the GCD datapath, with result delivery over SPI. It accepts operand pairs on a valid/ready handshake and launches the external GCD engine. It waits for completion with a timeout, then serializes a header byte plus the result as one SPI mode-0 frame on the `je` pins. It replaces the free-running glue around the GCD core in `gcd_SPI` with a defined, testable sequence.

---
 rtl/gcd_spi_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/gcd_spi_ctrl.sv
// gcd_spi_ctrl: accepts operand pairs, launches the external GCD engine with a timeout,
// and delivers {err, seq, result} as one SPI mode-0 frame on je = {sclk, mosi, cs_n}.
module gcd_spi_ctrl #(
   parameter int DW      = 8,
   parameter int CLK_DIV = 4,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_btn,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [DW-1:0] op_a,
   input  logic [DW-1:0] op_b,
   output logic          gcd_start,
   output logic [DW-1:0] gcd_a,
   output logic [DW-1:0] gcd_b,
   input  logic          gcd_done,
   input  logic [DW-1:0] gcd_rslt,
   output logic [2:0]    je,
   output logic          busy
);
   localparam int FW = 8 + DW;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(FW);

   typedef enum logic [2:0] {IDLE, START, WAIT, SEND, GAP} state_t;

   state_t        state, state_n;
   logic [TW-1:0] tmo;
   logic [CW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt;
   logic [FW-1:0] sh;
   logic [6:0]    seq;
   logic          cs_n, mosi, sclk;
   logic          hs, zero, tick, last, expire, load, err_n;
   logic [DW-1:0] res_n;

   assign hs     = state == IDLE && op_valid && op_ready;
   assign zero   = op_a == '0 || op_b == '0;
   assign tick   = div_cnt == CW'(CLK_DIV - 1);
   assign last   = tick && sclk && bit_cnt == BW'(FW - 1);
   assign expire = tmo == TW'(1);
   assign load   = state != SEND && state_n == SEND;

   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn)
         state <= IDLE;
      else
         state <= state_n;
   end

   // err_n/res_n are only meaningful on the transition into SEND
   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      res_n   = '0;
      case (state)
         IDLE: begin
            state_n = hs ? (zero ? SEND : START) : IDLE;
            res_n   = op_a | op_b;
         end
         START: state_n = WAIT;
         WAIT: begin
            state_n = gcd_done || expire ? SEND : WAIT;
            err_n   = !gcd_done;
            res_n   = gcd_done ? gcd_rslt : '0;
         end
         SEND: state_n = last ? GAP : SEND;
         GAP: state_n = tick ? IDLE : GAP;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         op_ready <= 1'b0;
         gcd_a    <= '0;
         gcd_b    <= '0;
         tmo      <= '0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         sh       <= '0;
         seq      <= '0;
         cs_n     <= 1'b1;
         mosi     <= 1'b0;
         sclk     <= 1'b0;
      end else begin
         op_ready <= state_n == IDLE;
         if (hs) begin
            gcd_a <= op_a;
            gcd_b <= op_b;
         end
         if (state == START)
            tmo <= TW'(TIMEOUT);
         else if (state == WAIT)
            tmo <= tmo - TW'(1);
         if (load) begin
            sh      <= {err_n, seq, res_n};
            mosi    <= err_n;
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
         end else if (state == SEND) begin
            div_cnt <= tick ? '0 : div_cnt + CW'(1);
            if (tick)
               sclk <= !sclk;
            // mosi moves only on the falling sclk; the last fall also closes the frame
            if (tick && sclk && last) begin
               cs_n <= 1'b1;
               mosi <= 1'b0;
            end else if (tick && sclk) begin
               bit_cnt <= bit_cnt + BW'(1);
               sh      <= sh << 1;
               mosi    <= sh[FW-2];
            end
         end else if (state == GAP) begin
            div_cnt <= tick ? '0 : div_cnt + CW'(1);
            if (tick)
               seq <= seq + 7'd1;
         end
      end
   end

   always_comb begin
      gcd_start = state == START;
      busy      = state != IDLE;
      je        = {sclk, mosi, cs_n};
   end
endmodule
